// File: rtl/hazard_ctrl_unit.sv
// Hazard/sequencing controller for the ID stage: load-use stalls, branch squash, RET wait, IRQ entry.
// Outputs are combinational from state, counter and current inputs; all outputs are forced low during reset.
module hazard_ctrl_unit #(
  parameter int RET_STALL    = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       id_is_ret,
  input  logic       ex_mem_read,
  input  logic [1:0] ex_rd,
  input  logic       branch_taken_ex,
  input  logic       irq,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ret_pc_sel,
  output logic       irq_take,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RET_WAIT, IRQ_DRAIN, IRQ_VECTOR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             irq_pending;
  logic             load_use;

  assign load_use = ex_mem_read &
                    ((id_uses_ra & (id_ra == ex_rd)) | (id_uses_rb & (id_rb == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      irq_pending <= 1'b0;
    end else begin
      // A new request in the vector cycle is kept rather than dropped.
      irq_pending <= irq | (irq_pending & (state != IRQ_VECTOR));
      case (state)
        IDLE: begin
          if (!branch_taken_ex && !load_use) begin
            if (id_is_ret) begin
              state <= RET_WAIT;
              cnt   <= CNT_W'(RET_STALL - 1);
            end else if (irq_pending) begin
              state <= IRQ_DRAIN;
              cnt   <= CNT_W'(DRAIN_CYCLES - 1);
            end
          end
        end
        RET_WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        IRQ_DRAIN: begin
          if (cnt == '0) state <= IRQ_VECTOR;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ret_pc_sel  = 1'b0;
    irq_take    = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      busy        = (state != IDLE);
      case (state)
        IDLE: begin
          if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_is_ret || irq_pending) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        RET_WAIT: begin
          if_id_flush = 1'b1;
          pc_write    = (cnt == '0);
          ret_pc_sel  = (cnt == '0);
        end
        IRQ_DRAIN: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = branch_taken_ex;
        end
        default: begin
          if_id_flush = 1'b1;
          irq_take    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: stimulus pushes expected outputs, a monitor pops and compares at negedge.
module tb_hazard_ctrl_unit;

  localparam int RET_STALL    = 3;
  localparam int DRAIN_CYCLES = 3;

  typedef struct packed {
    logic       rst;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       ura;
    logic       urb;
    logic       ret;
    logic       exmr;
    logic [1:0] exrd;
    logic       br;
    logic       irq;
  } in_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] id_ra = '0, id_rb = '0, ex_rd = '0;
  logic id_uses_ra = 0, id_uses_rb = 0, id_is_ret = 0, ex_mem_read = 0;
  logic branch_taken_ex = 0, irq = 0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ret_pc_sel, irq_take, busy;

  hazard_ctrl_unit #(.RET_STALL(RET_STALL), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_is_ret(id_is_ret), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken_ex(branch_taken_ex), .irq(irq),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ret_pc_sel(ret_pc_sel), .irq_take(irq_take), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected vector order: pc_write, if_id_write, if_id_flush, id_ex_flush, ret_pc_sel, irq_take, busy
  typedef struct packed {
    int       cyc;
    logic [6:0] v;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Reference model: remaining-cycle counts of each pending activity.
  int ret_left   = 0;   // RET_WAIT cycles still to come (last one selects the return PC)
  int drain_left = 0;   // drain cycles still to come before the vector
  bit vec_now    = 0;   // the vector cycle is the next cycle
  bit pend       = 0;   // interrupt latched and not yet taken

  function automatic in_t mk(bit r, bit ret, bit exmr, bit [1:0] exrd, bit [1:0] ra, bit ura,
                             bit [1:0] rb, bit urb, bit br, bit irq_i);
    in_t t;
    t.rst = r; t.ret = ret; t.exmr = exmr; t.exrd = exrd; t.ra = ra; t.ura = ura;
    t.rb = rb; t.urb = urb; t.br = br; t.irq = irq_i;
    return t;
  endfunction

  task automatic cyc(input in_t t);
    bit pw, iw, ifl, efl, rsel, take, bsy, lu;
    exp_t e;
    @(posedge clk);
    #1;
    rst = t.rst; id_ra = t.ra; id_rb = t.rb; id_uses_ra = t.ura; id_uses_rb = t.urb;
    id_is_ret = t.ret; ex_mem_read = t.exmr; ex_rd = t.exrd; branch_taken_ex = t.br; irq = t.irq;
    {pw, iw, ifl, efl, rsel, take, bsy} = '0;
    if (!t.rst) begin
      ret_left = 0; drain_left = 0; vec_now = 0; pend = 0;
    end else begin
      bsy = (ret_left > 0) || (drain_left > 0) || vec_now;
      iw  = 1;
      lu  = t.exmr && ((t.ura && t.ra == t.exrd) || (t.urb && t.rb == t.exrd));
      if (ret_left > 0) begin
        ifl = 1; pw = (ret_left == 1); rsel = (ret_left == 1);
        ret_left--;
      end else if (drain_left > 0) begin
        ifl = 1; efl = t.br;
        drain_left--;
        if (drain_left == 0) vec_now = 1;
      end else if (vec_now) begin
        take = 1; pw = 1; ifl = 1;
        vec_now = 0; pend = 0;
      end else if (t.br) begin
        pw = 1; ifl = 1; efl = 1;
      end else if (lu) begin
        iw = 0; efl = 1;
      end else if (t.ret) begin
        ifl = 1; ret_left = RET_STALL;
      end else if (pend) begin
        ifl = 1; drain_left = DRAIN_CYCLES;
      end else begin
        pw = 1;
      end
      if (t.irq) pend = 1;
    end
    e.cyc = cycle;
    e.v   = {pw, iw, ifl, efl, rsel, take, bsy};
    exp_q.push_back(e);
    cycle++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_write, if_id_write, if_id_flush, id_ex_flush, ret_pc_sel, irq_take, busy};
        n_tests++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL outs cycle %0d: got %b expected %b (pcw,ifw,iff,exf,ret,take,busy)",
                   e.cyc, got, e.v);
        end
      end
    end
  end

  initial begin : stim
    in_t idle;
    int r;
    idle = mk(1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) cyc(idle);
    // load-use, then release, then same registers without use
    cyc(mk(1, 0, 1, 2'd2, 2'd2, 1, 2'd0, 0, 0, 0));
    cyc(mk(1, 0, 0, 2'd2, 2'd2, 1, 2'd0, 0, 0, 0));
    cyc(mk(1, 0, 1, 2'd2, 2'd2, 0, 2'd0, 0, 0, 0));
    cyc(mk(1, 0, 1, 2'd1, 2'd0, 0, 2'd1, 1, 0, 0));
    // branch wins over load-use and RET
    cyc(mk(1, 1, 1, 2'd3, 2'd3, 1, 2'd0, 0, 1, 0));
    // RET sequence
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) cyc(idle);
    // IRQ pulse and pending clear
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (10) cyc(idle);
    // IRQ during the second RET_WAIT cycle
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(idle);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (10) cyc(idle);
    // branch during drain
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(idle);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (5) cyc(idle);
    // reset during drain with one cycle left: the interrupt is lost
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(idle);
    cyc(idle);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (6) cyc(idle);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      cyc(mk(r != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0));
    end
    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
